iso7816_t0_tx: RTL



---
 rtl/iso7816_pkg.sv | 30 +++
 rtl/etu_timer.sv | 32 +++
 rtl/iso7816_t0_tx.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/iso7816_pkg.sv
// Shared definitions for the ISO7816 T=0 character transmitter and its companion receiver.
package iso7816_pkg;

  localparam int DATA_BITS     = 8;
  localparam int BIT_IDX_W     = $clog2(DATA_BITS);
  localparam int ERR_WAIT_ETUS = 3;
  localparam int ERR_CNT_W     = $clog2(ERR_WAIT_ETUS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_GUARD,
    ST_EXTRA,
    ST_ERR_WAIT
  } tx_state_e;

  // Parity bit that makes data plus parity carry an odd (odd=1) or even number of ones.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  function automatic logic data_bit(input logic [DATA_BITS-1:0] data,
                                    input logic [BIT_IDX_W-1:0] idx,
                                    input logic                 msb_first);
    return msb_first ? data[BIT_IDX_W'(DATA_BITS - 1) - idx] : data[idx];
  endfunction

endpackage

// File: rtl/etu_timer.sv
// Elementary time unit timer: free-running 0..clocksPerBit counter with a terminal-count strobe.
module etu_timer #(
  parameter int CLOCK_PER_BIT_WIDTH = 13
) (
  input  logic                           clk,
  input  logic                           nReset,
  input  logic                           load,
  input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
  output logic                           etuEnd,
  output logic [CLOCK_PER_BIT_WIDTH-1:0] count
);

  logic [CLOCK_PER_BIT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every always_comb output gets an unconditional value first so no latch is inferred.
    count_d = count_q + 1'b1;
    if (load || (count_q == clocksPerBit)) begin
      count_d = '0;
    end
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) count_q <= '0;
    else         count_q <= count_d;
  end

  assign etuEnd = (count_q == clocksPerBit);
  assign count  = count_q;

endmodule

// File: rtl/iso7816_t0_tx.sv
// ISO7816 T=0 character transmitter: frames one byte, watches the guard time for a
// receiver error signal and retransmits the same byte up to a programmable limit.
module iso7816_t0_tx
  import iso7816_pkg::*;
#(
  parameter int   CLOCK_PER_BIT_WIDTH = 13,
  parameter int   RETRY_WIDTH         = 3,
  parameter logic START_BIT           = 1'b0
) (
  input  logic                           clk,
  input  logic                           nReset,
  input  logic [DATA_BITS-1:0]           txData,
  input  logic                           startTx,
  input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
  input  logic [7:0]                     extraGuard,
  input  logic [RETRY_WIDTH-1:0]         maxRetries,
  input  logic                           oddParity,
  input  logic                           msbFirst,
  input  logic                           serialIn,
  output logic                           serialOut,
  output logic                           isTx,
  output logic                           busy,
  output logic                           done,
  output logic                           failFlag,
  output logic [RETRY_WIDTH-1:0]         retryCount
);

  tx_state_e                      state_q, state_d;
  logic [DATA_BITS-1:0]           data_q, data_d;
  logic [CLOCK_PER_BIT_WIDTH-1:0] cpb_q, cpb_d;
  logic [7:0]                     extra_q, extra_d;
  logic [RETRY_WIDTH-1:0]         max_q, max_d;
  logic                           odd_q, odd_d;
  logic                           msb_q, msb_d;
  logic [BIT_IDX_W-1:0]           bit_idx_q, bit_idx_d;
  logic [7:0]                     extra_cnt_q, extra_cnt_d;
  logic [ERR_CNT_W-1:0]           err_cnt_q, err_cnt_d;
  logic                           err_hi_q, err_hi_d;
  logic                           guard_armed_q, guard_armed_d;
  logic [RETRY_WIDTH-1:0]         retry_q, retry_d;
  logic                           fail_q, fail_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           tx_q, tx_d;
  logic                           sout_q, sout_d;

  logic                           timer_load;
  logic                           etu_end;
  logic [CLOCK_PER_BIT_WIDTH-1:0] timer_count;
  logic                           sample_now;

  etu_timer #(
    .CLOCK_PER_BIT_WIDTH(CLOCK_PER_BIT_WIDTH)
  ) u_etu_timer (
    .clk         (clk),
    .nReset      (nReset),
    .load        (timer_load),
    .clocksPerBit(cpb_q),
    .etuEnd      (etu_end),
    .count       (timer_count)
  );

  // The error signal is sampled on the first cycle of the ETU following the guard ETU.
  assign sample_now = guard_armed_q && (timer_count == '0);

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    cpb_d         = cpb_q;
    extra_d       = extra_q;
    max_d         = max_q;
    odd_d         = odd_q;
    msb_d         = msb_q;
    bit_idx_d     = bit_idx_q;
    extra_cnt_d   = extra_cnt_q;
    err_cnt_d     = err_cnt_q;
    err_hi_d      = err_hi_q;
    guard_armed_d = guard_armed_q;
    retry_d       = retry_q;
    fail_d        = fail_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    tx_d          = tx_q;
    sout_d        = sout_q;
    timer_load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_load = 1'b1;
        if (startTx && !done_q) begin
          state_d = ST_START;
          data_d  = txData;
          cpb_d   = clocksPerBit;
          extra_d = extraGuard;
          max_d   = maxRetries;
          odd_d   = oddParity;
          msb_d   = msbFirst;
          retry_d = '0;
          fail_d  = 1'b0;
          busy_d  = 1'b1;
          tx_d    = 1'b1;
          sout_d  = START_BIT;
        end
      end
      ST_START: begin
        if (etu_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          sout_d    = data_bit(data_q, '0, msb_q);
        end
      end
      ST_DATA: begin
        if (etu_end) begin
          if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
            state_d = ST_PARITY;
            sout_d  = parity_bit(data_q, odd_q);
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            sout_d    = data_bit(data_q, bit_idx_q + 1'b1, msb_q);
          end
        end
      end
      ST_PARITY: begin
        if (etu_end) begin
          state_d       = ST_GUARD;
          guard_armed_d = 1'b0;
          tx_d          = 1'b0;
          sout_d        = 1'b1;
        end
      end
      ST_GUARD: begin
        if (sample_now) begin
          guard_armed_d = 1'b0;
          if (!serialIn) begin
            state_d    = ST_ERR_WAIT;
            timer_load = 1'b1;
            err_cnt_d  = '0;
            err_hi_d   = 1'b0;
          end else begin
            state_d     = ST_EXTRA;
            extra_cnt_d = '0;
          end
        end else if (etu_end) begin
          guard_armed_d = 1'b1;
        end
      end
      ST_EXTRA: begin
        if (etu_end) begin
          if (extra_cnt_q == extra_q) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            extra_cnt_d = extra_cnt_q + 1'b1;
          end
        end
      end
      ST_ERR_WAIT: begin
        if (!err_hi_q) begin
          if (etu_end) begin
            if (err_cnt_q == ERR_CNT_W'(ERR_WAIT_ETUS - 1)) err_hi_d  = 1'b1;
            else                                            err_cnt_d = err_cnt_q + 1'b1;
          end
        end else if (!serialIn) begin
          // Receiver still holding the line: restart the required high ETU.
          timer_load = 1'b1;
        end else if (etu_end) begin
          if (retry_q < max_q) begin
            state_d = ST_START;
            retry_d = retry_q + 1'b1;
            tx_d    = 1'b1;
            sout_d  = START_BIT;
          end else begin
            state_d = ST_IDLE;
            fail_d  = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q       <= ST_IDLE;
      data_q        <= '0;
      cpb_q         <= '0;
      extra_q       <= '0;
      max_q         <= '0;
      odd_q         <= 1'b0;
      msb_q         <= 1'b0;
      bit_idx_q     <= '0;
      extra_cnt_q   <= '0;
      err_cnt_q     <= '0;
      err_hi_q      <= 1'b0;
      guard_armed_q <= 1'b0;
      retry_q       <= '0;
      fail_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      tx_q          <= 1'b0;
      sout_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      cpb_q         <= cpb_d;
      extra_q       <= extra_d;
      max_q         <= max_d;
      odd_q         <= odd_d;
      msb_q         <= msb_d;
      bit_idx_q     <= bit_idx_d;
      extra_cnt_q   <= extra_cnt_d;
      err_cnt_q     <= err_cnt_d;
      err_hi_q      <= err_hi_d;
      guard_armed_q <= guard_armed_d;
      retry_q       <= retry_d;
      fail_q        <= fail_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      tx_q          <= tx_d;
      sout_q        <= sout_d;
    end
  end

  assign serialOut  = sout_q;
  assign isTx       = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign failFlag   = fail_q;
  assign retryCount = retry_q;

endmodule
